// File: rtl/bitser_alu_pkg.sv
// Shared types for the bit-serial accumulator ALU: opcodes, FSM states, opcode width.
package bitser_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    LOAD = 3'b000,
    ADD  = 3'b001,
    SUB  = 3'b010,
    AND  = 3'b011,
    OR   = 3'b100,
    XOR  = 3'b101,
    NOT  = 3'b110,
    NOP  = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bitser_alu_if.sv
// Instruction/result bundle between the fetch/execute FSM (master) and bitser_alu (slave).
interface bitser_alu_if
  import bitser_pkg::*;
#(
  parameter int WIDTH = 8
);
  logic             start;
  op_t              op;
  logic [WIDTH-1:0] operand;
  logic             clr;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] acc_out;
  logic             serial_out;
  logic             serial_vld;
  logic             zf;
  logic             cf;

  modport master (
    output start, op, operand, clr,
    input  busy, done, acc_out, serial_out, serial_vld, zf, cf
  );

  modport slave (
    input  start, op, operand, clr,
    output busy, done, acc_out, serial_out, serial_vld, zf, cf
  );
endinterface

// File: rtl/bitser_alu_slice.sv
// One-bit ALU slice: result bit and carry-out for a single LSB-first step.
module bitser_alu_slice
  import bitser_pkg::*;
(
  input  logic a_i,
  input  logic b_i,
  input  logic cin_i,
  input  op_t  op_i,
  output logic r_o,
  output logic cout_o
);

  logic b_eff;

  // NOTE: every output of a combinational block gets a default first so no path can infer a latch.
  always_comb begin
    r_o    = 1'b0;
    cout_o = 1'b0;
    b_eff  = (op_i == SUB) ? ~b_i : b_i;
    case (op_i)
      LOAD:    r_o = b_i;
      ADD,
      SUB: begin
        // SUB is a + ~b with the carry preset to 1 before the first bit.
        r_o    = a_i ^ b_eff ^ cin_i;
        cout_o = (a_i & b_eff) | (cin_i & (a_i ^ b_eff));
      end
      AND:     r_o = a_i & b_i;
      OR:      r_o = a_i | b_i;
      XOR:     r_o = a_i ^ b_i;
      NOT:     r_o = ~a_i;
      NOP:     r_o = a_i;
      default: r_o = a_i;
    endcase
  end

endmodule

// File: rtl/bitser_alu.sv
// Bit-serial accumulator ALU: FSM, bit counter, accumulator/operand shifters and flags.
// Optional flags: define BITSER_ALU_FLAGS_EN to register zf/cf; otherwise both are tied to 0.
module bitser_alu
  import bitser_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  bitser_alu_if.slave  bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  op_t              op_q, op_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic r_bit;
  logic c_out;

  bitser_alu_slice u_slice (
    .a_i    (acc_q[0]),
    .b_i    (b_q[0]),
    .cin_i  (carry_q),
    .op_i   (op_q),
    .r_o    (r_bit),
    .cout_o (c_out)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    b_d     = b_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          b_d     = bus.operand;
          carry_d = (bus.op == SUB);
          cnt_d   = '0;
          state_d = SHIFT;
        end else if (bus.clr) begin
          acc_d = '0;
        end
      end
      SHIFT: begin
        acc_d   = {r_bit, acc_q[WIDTH-1:1]};
        b_d     = b_q >> 1;
        carry_d = c_out;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= LOAD;
      acc_q   <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef BITSER_ALU_FLAGS_EN
  logic zacc_q, zacc_d;
  logic zf_q, zf_d;
  logic cf_q, cf_d;

  always_comb begin
    zacc_d = zacc_q;
    zf_d   = zf_q;
    cf_d   = cf_q;
    case (state_q)
      IDLE:  if (bus.start) zacc_d = 1'b1;
      SHIFT: zacc_d = zacc_q & ~r_bit;
      DONE: begin
        zf_d = zacc_q;
        cf_d = ((op_q == ADD) || (op_q == SUB)) ? carry_q : 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zacc_q <= 1'b0;
      zf_q   <= 1'b0;
      cf_q   <= 1'b0;
    end else begin
      zacc_q <= zacc_d;
      zf_q   <= zf_d;
      cf_q   <= cf_d;
    end
  end

  assign bus.zf = zf_q;
  assign bus.cf = cf_q;
`else
  assign bus.zf = 1'b0;
  assign bus.cf = 1'b0;
`endif

  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = (state_q == DONE);
  assign bus.serial_vld = (state_q == SHIFT);
  assign bus.serial_out = (state_q == SHIFT) ? r_bit : 1'b0;
  assign bus.acc_out    = acc_q;

endmodule

// File: tb/tb_bitser_alu.sv
// Directed bench for bitser_alu: word-level reference model compared every cycle, plus literal vectors.
module tb_bitser_alu;
  import bitser_pkg::*;

  localparam int W = 8;
`ifdef BITSER_ALU_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bitser_alu_if #(.WIDTH(W)) bus ();

  bitser_alu #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Word-level reference: the whole result is computed at accept time with plain arithmetic.
  function automatic logic [W:0] alu_word(op_t o, logic [W-1:0] a, logic [W-1:0] b);
    case (o)
      LOAD:    return {1'b0, b};
      ADD:     return {1'b0, a} + {1'b0, b};
      SUB:     return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      AND:     return {1'b0, a & b};
      OR:      return {1'b0, a | b};
      XOR:     return {1'b0, a ^ b};
      NOT:     return {1'b0, ~a};
      default: return {1'b0, a};
    endcase
  endfunction

  // phase: 0 idle, 1..W shift cycle number, W+1 done cycle.
  int         phase;
  logic [W-1:0] m_acc, m_res;
  logic         m_cout, m_zf, m_cf;
  op_t          m_op;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= 0;
      m_acc  <= '0;
      m_res  <= '0;
      m_cout <= 1'b0;
      m_zf   <= 1'b0;
      m_cf   <= 1'b0;
      m_op   <= LOAD;
    end else if (phase == 0) begin
      if (bus.start) begin
        {m_cout, m_res} <= alu_word(bus.op, m_acc, bus.operand);
        m_op  <= bus.op;
        phase <= 1;
      end else if (bus.clr) begin
        m_acc <= '0;
      end
    end else if (phase <= W) begin
      phase <= phase + 1;
    end else begin
      m_acc <= m_res;
      m_zf  <= (m_res == '0);
      m_cf  <= ((m_op == ADD) || (m_op == SUB)) ? m_cout : 1'b0;
      phase <= 0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy",       bus.busy,       phase != 0);
      check("done",       bus.done,       phase == W + 1);
      check("serial_vld", bus.serial_vld, (phase >= 1) && (phase <= W));
      check("serial_out", bus.serial_out, ((phase >= 1) && (phase <= W)) ? m_res[phase-1] : 1'b0);
      if (phase == 0) check("acc_out", bus.acc_out, m_acc);
      check("zf", bus.zf, FLAGS ? m_zf : 1'b0);
      check("cf", bus.cf, FLAGS ? m_cf : 1'b0);
    end
  end

  bit ser_q[$];
  always @(negedge clk) if (bus.serial_vld) ser_q.push_back(bus.serial_out);

  // Returns edges from acceptance to the done cycle; leaves the bench one cycle into IDLE.
  task automatic run_op(input op_t o, input logic [W-1:0] b, output int lat);
    bit seen = 1'b0;
    @(posedge clk); #2;
    bus.start = 1'b1; bus.op = o; bus.operand = b;
    @(posedge clk); #2;
    bus.start = 1'b0; bus.op = XOR; bus.operand = 8'hA5;
    lat = 1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) begin seen = 1'b1; break; end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic expect_result(input string tag, input logic [W-1:0] acc, input logic zf, input logic cf);
    check({tag, "_acc"}, bus.acc_out, acc);
    check({tag, "_zf"},  bus.zf, FLAGS ? zf : 1'b0);
    check({tag, "_cf"},  bus.cf, FLAGS ? cf : 1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int n_done;
    bit exp_ser [8] = '{0, 1, 0, 1, 1, 0, 1, 0};

    bus.start = 1'b0; bus.clr = 1'b0; bus.op = NOP; bus.operand = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_vld",  bus.serial_vld, 0);
    check("rst_sout", bus.serial_out, 0);
    expect_result("rst", 8'h00, 1'b0, 1'b0);
    #3 rst_n = 1'b1;

    // LOAD from reset: serial stream, latency, result
    ser_q.delete();
    run_op(LOAD, 8'h5A, lat);
    check("load_latency", lat, 9);
    check("load_nbits", ser_q.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < ser_q.size()) check($sformatf("load_ser%0d", i), ser_q[i], exp_ser[i]);
    expect_result("load5a", 8'h5A, 1'b0, 1'b0);

    // ADD with and without carry-out
    run_op(ADD, 8'hC8, lat);  expect_result("add_c8", 8'h22, 1'b0, 1'b1);
    run_op(LOAD, 8'hFE, lat); run_op(ADD, 8'h01, lat);
    expect_result("add_01", 8'hFF, 1'b0, 1'b0);

    // SUB to zero (no borrow) and below zero (borrow)
    run_op(LOAD, 8'h22, lat); run_op(SUB, 8'h22, lat);
    expect_result("sub_22", 8'h00, 1'b1, 1'b1);
    run_op(SUB, 8'h01, lat);  expect_result("sub_01", 8'hFF, 1'b0, 1'b0);

    // Logic ops clear cf
    run_op(AND, 8'h0F, lat);  expect_result("and", 8'h0F, 1'b0, 1'b0);
    run_op(OR,  8'hA0, lat);  expect_result("or",  8'hAF, 1'b0, 1'b0);
    run_op(XOR, 8'hFF, lat);  expect_result("xor", 8'h50, 1'b0, 1'b0);
    run_op(NOT, 8'h00, lat);  expect_result("not", 8'hAF, 1'b0, 1'b0);
    run_op(NOP, 8'h12, lat);  expect_result("nop", 8'hAF, 1'b0, 1'b0);

    // start held for 20 cycles: exactly two back-to-back ops
    run_op(LOAD, 8'h10, lat);
    @(posedge clk); #2;
    bus.start = 1'b1; bus.op = ADD; bus.operand = 8'h01;
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.done) n_done++;
    end
    bus.start = 1'b0;
    check("held_start_ops", n_done, 2);
    repeat (2) @(posedge clk); #1;
    expect_result("held_start", 8'h12, 1'b0, 1'b0);

    // clr during SHIFT is ignored
    @(posedge clk); #2;
    bus.start = 1'b1; bus.op = OR; bus.operand = 8'h01;
    @(posedge clk); #2; bus.start = 1'b0;
    @(posedge clk); #2; bus.clr = 1'b1;
    @(posedge clk); #2; bus.clr = 1'b0;
    repeat (10) @(posedge clk); #1;
    check("clr_shift_acc", bus.acc_out, 8'h13);

    // clr in IDLE clears acc
    @(posedge clk); #2; bus.clr = 1'b1;
    @(posedge clk); #1;
    check("clr_idle_acc", bus.acc_out, 8'h00);
    #1 bus.clr = 1'b0;

    // async reset in the 4th SHIFT cycle of an ADD
    run_op(LOAD, 8'h40, lat);
    @(posedge clk); #2;
    bus.start = 1'b1; bus.op = ADD; bus.operand = 8'h05;
    @(posedge clk); #2; bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("pre_rst_vld", bus.serial_vld, 1);
    #1 rst_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_vld",  bus.serial_vld, 0);
    check("abort_acc",  bus.acc_out, 8'h00);
    @(posedge clk); #3 rst_n = 1'b1;
    run_op(LOAD, 8'h33, lat);
    expect_result("post_rst", 8'h33, 1'b0, 1'b0);

    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
